// File: rtl/fetch_queue_if.sv
// Fetch front-end bundle: SRAM-like instruction port, redirect input and the
// valid/ready handshake toward decode.
interface fetch_queue_if;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        id_adef;

  modport master (
    output inst_sram_req, inst_sram_addr,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    input  redirect_valid, redirect_pc,
    output id_valid, id_pc, id_instr, id_adef,
    input  id_ready
  );

  modport slave (
    input  inst_sram_req, inst_sram_addr,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    output redirect_valid, redirect_pc,
    input  id_valid, id_pc, id_instr, id_adef,
    output id_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC-sequential requests, response queue to decode,
// redirect flush with discard of stale in-flight responses.
module fetch_queue #(
  parameter logic [31:0] RESET_PC        = 32'h1c00_0000,
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input logic           clk,
  input logic           reset,
  fetch_queue_if.master bus
);

  localparam int QW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 2);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int SW = CW + OW;

  logic [31:0]   fetch_pc;
  logic [CW-1:0] count;
  logic [OW-1:0] outstanding, outstanding_nxt, discard_cnt, live_out;
  logic          held, held_stale, adef_stall;
  logic [31:0]   held_addr;
  logic [QW-1:0] rd_ptr, wr_ptr;
  logic [PW-1:0] pf_rd, pf_wr;
  logic [31:0]   pc_fifo [MAX_OUTSTANDING];
  logic [31:0]   q_pc    [DEPTH];
  logic [31:0]   q_instr [DEPTH];
  logic          q_adef  [DEPTH];

  logic          issue_ok, req, accept, drop, push_data, adef_push, pop, redirect;
  logic [SW-1:0] occupancy;

  function automatic logic [PW-1:0] pf_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  assign redirect = bus.redirect_valid;

  // Every live in-flight request owns a queue slot, so a response can always be pushed.
  assign live_out  = (outstanding > discard_cnt) ? outstanding - discard_cnt : '0;
  assign occupancy = SW'(count) + SW'(live_out);
  assign issue_ok  = !adef_stall && (fetch_pc[1:0] == 2'b00)
                     && (outstanding < OW'(MAX_OUTSTANDING))
                     && (occupancy < SW'(DEPTH));

  assign req    = !reset && (held || issue_ok);
  assign accept = req && bus.inst_sram_addr_ok;

  assign bus.inst_sram_req  = req;
  assign bus.inst_sram_addr = held ? held_addr : fetch_pc;

  assign drop      = bus.inst_sram_data_ok && (discard_cnt != '0);
  assign push_data = bus.inst_sram_data_ok && !drop && !redirect;
  assign adef_push = !redirect && !adef_stall && (fetch_pc[1:0] != 2'b00) && !held
                     && (outstanding == discard_cnt) && (count < CW'(DEPTH));
  assign pop       = bus.id_valid && bus.id_ready && !redirect;

  always_comb begin
    outstanding_nxt = outstanding;
    if (accept && !bus.inst_sram_data_ok)
      outstanding_nxt = outstanding + OW'(1);
    else if (!accept && bus.inst_sram_data_ok)
      outstanding_nxt = outstanding - OW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      discard_cnt <= '0;
      held        <= 1'b0;
      held_stale  <= 1'b0;
      held_addr   <= '0;
      adef_stall  <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      pf_rd       <= '0;
      pf_wr       <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (accept)
        pf_wr <= pf_inc(pf_wr);
      if (bus.inst_sram_data_ok)
        pf_rd <= pf_inc(pf_rd);

      // A request left waiting for addr_ok is stale if any redirect arrived while it waited.
      held       <= req && !bus.inst_sram_addr_ok;
      held_stale <= req && !bus.inst_sram_addr_ok && ((held && held_stale) || redirect);
      if (req && !bus.inst_sram_addr_ok)
        held_addr <= bus.inst_sram_addr;

      if (redirect) begin
        fetch_pc    <= bus.redirect_pc;
        adef_stall  <= 1'b0;
        count       <= '0;
        rd_ptr      <= '0;
        wr_ptr      <= '0;
        discard_cnt <= outstanding_nxt + OW'(req && !bus.inst_sram_addr_ok);
      end else begin
        if (accept && !(held && held_stale))
          fetch_pc <= fetch_pc + 32'd4;
        if (drop)
          discard_cnt <= discard_cnt - OW'(1);
        if (adef_push)
          adef_stall <= 1'b1;
        if (push_data || adef_push)
          wr_ptr <= wr_ptr + QW'(1);
        if (pop)
          rd_ptr <= rd_ptr + QW'(1);
        if ((push_data || adef_push) && !pop)
          count <= count + CW'(1);
        else if (!(push_data || adef_push) && pop)
          count <= count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && (push_data || adef_push)) begin
      q_pc[wr_ptr]    <= push_data ? pc_fifo[pf_rd] : fetch_pc;
      q_instr[wr_ptr] <= push_data ? bus.inst_sram_rdata : 32'h0;
      q_adef[wr_ptr]  <= !push_data;
    end
    if (!reset && accept)
      pc_fifo[pf_wr] <= bus.inst_sram_addr;
  end

  assign bus.id_valid = (count != '0);
  assign bus.id_pc    = q_pc[rd_ptr];
  assign bus.id_instr = q_instr[rd_ptr];
  assign bus.id_adef  = bus.id_valid && q_adef[rd_ptr];

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue: in-order SRAM responder plus a sequential-PC
// reference model of the fetch and decode streams.
module tb_fetch_queue;
  localparam logic [31:0] RESET_PC = 32'h1c00_0000;
  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fetch_queue_if bus();

  fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct { logic [31:0] addr; bit stale; } pend_t;

  int n_cmp = 0;
  int n_fail = 0;
  int n_live_acc = 0;
  int n_pops = 0;
  pend_t pend[$];
  int live = 0;
  logic [31:0] exp_fetch_pc = RESET_PC;
  logic [31:0] exp_pop_pc = RESET_PC;
  bit held_prev = 0, held_prev_stale = 0, adef_pushed = 0;
  logic [31:0] held_prev_addr = '0;
  logic s_req, s_vld, s_adef;
  logic [31:0] s_addr, s_pc, s_instr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9e37_79b9) ^ 32'h5a5a_0f0f;
  endfunction

  // One clock: drive inputs, sample after settling, check against the model, advance the model.
  task automatic drive_cycle(input bit rst, input bit rdy, input bit aok, input bit dok,
                             input bit redir, input logic [31:0] rpc);
    bit dok_now, accept, st, pop, adef_mode, adef_now, all_stale;
    pend_t p;
    @(negedge clk);
    reset = rst;
    dok_now = dok && (pend.size() > 0) && !rst;
    bus.inst_sram_addr_ok = aok;
    bus.inst_sram_data_ok = dok_now;
    bus.inst_sram_rdata   = dok_now ? mem_word(pend[0].addr) : $urandom;
    bus.id_ready          = rdy;
    bus.redirect_valid    = redir && !rst;
    bus.redirect_pc       = rpc;
    #1;
    s_req = bus.inst_sram_req;  s_addr = bus.inst_sram_addr;
    s_vld = bus.id_valid;       s_pc = bus.id_pc;
    s_instr = bus.id_instr;     s_adef = bus.id_adef;
    if (rst) begin
      n_cmp++;
      if (s_req !== 1'b0) begin
        n_fail++; $display("FAIL reset_req: req=%b expected 0", s_req);
      end
      @(posedge clk);
      pend.delete(); live = 0; held_prev = 0; held_prev_stale = 0; adef_pushed = 0;
      exp_fetch_pc = RESET_PC; exp_pop_pc = RESET_PC;
      return;
    end
    adef_mode = (exp_fetch_pc[1:0] != 2'b00);
    if (held_prev) begin
      n_cmp++;
      if (s_req !== 1'b1 || s_addr !== held_prev_addr) begin
        n_fail++; $display("FAIL hold: req=%b addr=%h expected 1 %h", s_req, s_addr, held_prev_addr);
      end
    end else if (adef_mode) begin
      n_cmp++;
      if (s_req !== 1'b0) begin
        n_fail++; $display("FAIL adef_req: req=%b expected 0 (pc %h)", s_req, exp_fetch_pc);
      end
    end
    n_cmp++;
    if (s_vld !== (live > 0)) begin
      n_fail++; $display("FAIL id_valid: got %b expected %0d entries", s_vld, live);
    end
    accept = s_req && aok;
    st = redir || (held_prev && held_prev_stale);
    if (accept && !(held_prev && held_prev_stale)) begin
      n_cmp++;
      if (s_addr !== exp_fetch_pc) begin
        n_fail++; $display("FAIL fetch_addr: got %h expected %h", s_addr, exp_fetch_pc);
      end
      exp_fetch_pc = exp_fetch_pc + 32'd4;
      if (!st) n_live_acc++;
    end
    pop = s_vld && rdy && !redir;
    if (pop) begin
      n_cmp++;
      n_pops++;
      if (exp_pop_pc[1:0] != 2'b00) begin
        if (s_pc !== exp_pop_pc || s_instr !== 32'h0 || s_adef !== 1'b1) begin
          n_fail++;
          $display("FAIL id_adef_entry: pc=%h instr=%h adef=%b expected %h 0 1",
                   s_pc, s_instr, s_adef, exp_pop_pc);
        end
      end else begin
        if (s_pc !== exp_pop_pc || s_instr !== mem_word(exp_pop_pc) || s_adef !== 1'b0) begin
          n_fail++;
          $display("FAIL id_entry: pc=%h instr=%h adef=%b expected %h %h 0",
                   s_pc, s_instr, s_adef, exp_pop_pc, mem_word(exp_pop_pc));
        end
        exp_pop_pc = exp_pop_pc + 32'd4;
      end
    end
    all_stale = 1;
    foreach (pend[i]) if (!pend[i].stale) all_stale = 0;
    adef_now = adef_mode && !adef_pushed && !held_prev && all_stale && (live < DEPTH) && !redir;
    @(posedge clk);
    if (dok_now) begin
      p = pend.pop_front();
      if (!p.stale) live++;
    end
    if (accept) pend.push_back('{addr: s_addr, stale: st});
    if (pop) live--;
    if (adef_now) begin live++; adef_pushed = 1; end
    if (s_req && !aok) begin
      held_prev_stale = (held_prev && held_prev_stale) || redir;
      held_prev = 1; held_prev_addr = s_addr;
    end else begin
      held_prev = 0; held_prev_stale = 0;
    end
    if (redir) begin
      foreach (pend[i]) pend[i].stale = 1;
      live = 0; exp_fetch_pc = rpc; exp_pop_pc = rpc; adef_pushed = 0;
    end
    n_cmp++;
    if (pend.size() > MAXO || live > DEPTH) begin
      n_fail++; $display("FAIL occupancy: outstanding=%0d entries=%0d limits %0d %0d",
                         pend.size(), live, MAXO, DEPTH);
    end
  endtask

  task automatic test_reset();
    drive_cycle(1, 0, 0, 0, 0, 32'h0);
    drive_cycle(1, 0, 0, 0, 0, 32'h0);
    n_cmp++;
    if (s_vld !== 1'b0 || s_adef !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs: id_valid=%b id_adef=%b expected 0 0", s_vld, s_adef);
    end
  endtask

  task automatic test_sequential();
    logic r_req[4], r_vld[4];
    logic [31:0] r_addr[4], r_pc[4];
    for (int i = 0; i < 4; i++) begin
      drive_cycle(0, 1, 1, 1, 0, 32'h0);
      r_req[i] = s_req; r_addr[i] = s_addr; r_vld[i] = s_vld; r_pc[i] = s_pc;
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (r_req[i] !== 1'b1 || r_addr[i] !== RESET_PC + 32'(4 * i)) begin
        n_fail++; $display("FAIL seq_addr%0d: req=%b addr=%h expected 1 %h",
                           i, r_req[i], r_addr[i], RESET_PC + 32'(4 * i));
      end
    end
    n_cmp++;
    if (r_vld[1] !== 1'b0 || r_vld[2] !== 1'b1 || r_pc[2] !== RESET_PC) begin
      n_fail++; $display("FAIL seq_first_id: valid=%b,%b pc=%h expected 0,1 %h",
                         r_vld[1], r_vld[2], r_pc[2], RESET_PC);
    end
    for (int i = 0; i < 20; i++) drive_cycle(0, 1, 1, 1, 0, 32'h0);
  endtask

  task automatic test_backpressure();
    int a0, p0;
    drive_cycle(0, 0, 1, 1, 1, 32'h1c00_0200);
    a0 = n_live_acc;
    for (int i = 0; i < 20; i++) drive_cycle(0, 0, 1, 1, 0, 32'h0);
    n_cmp++;
    if (n_live_acc - a0 != DEPTH) begin
      n_fail++; $display("FAIL bp_fill: accepted %0d expected %0d", n_live_acc - a0, DEPTH);
    end
    n_cmp++;
    if (s_req !== 1'b0 || s_vld !== 1'b1) begin
      n_fail++; $display("FAIL bp_stall: req=%b valid=%b expected 0 1", s_req, s_vld);
    end
    p0 = n_pops;
    for (int i = 0; i < 30; i++) drive_cycle(0, 1, 1, 1, 0, 32'h0);
    n_cmp++;
    if (n_pops - p0 < 10) begin
      n_fail++; $display("FAIL bp_resume: popped %0d expected at least 10", n_pops - p0);
    end
  endtask

  task automatic test_redirect_outstanding();
    int k;
    bit found;
    k = 0;
    while (pend.size() < 2 && k < 10) begin drive_cycle(0, 1, 1, 0, 0, 32'h0); k++; end
    n_cmp++;
    if (pend.size() != 2) begin
      n_fail++; $display("FAIL redir_setup: outstanding %0d expected 2", pend.size());
    end
    drive_cycle(0, 1, 1, 0, 1, 32'h1c00_0100);
    k = 0; found = 0;
    while (!found && k < 20) begin drive_cycle(0, 0, 1, 1, 0, 32'h0); found = s_vld; k++; end
    n_cmp++;
    if (!found || s_pc !== 32'h1c00_0100 || s_instr !== mem_word(32'h1c00_0100)) begin
      n_fail++; $display("FAIL redir_first: found=%b pc=%h instr=%h expected 1 1c000100 %h",
                         found, s_pc, s_instr, mem_word(32'h1c00_0100));
    end
    for (int i = 0; i < 15; i++) drive_cycle(0, 1, 1, 1, 0, 32'h0);
  endtask

  task automatic test_redirect_held();
    int k;
    logic [31:0] h_addr;
    k = 0;
    drive_cycle(0, 1, 0, 1, 0, 32'h0);
    while (s_req !== 1'b1 && k < 10) begin drive_cycle(0, 1, 0, 1, 0, 32'h0); k++; end
    h_addr = s_addr;
    drive_cycle(0, 1, 0, 1, 1, 32'h1c00_0400);
    n_cmp++;
    if (s_req !== 1'b1 || s_addr !== h_addr) begin
      n_fail++; $display("FAIL held_redir: req=%b addr=%h expected 1 %h", s_req, s_addr, h_addr);
    end
    for (int i = 0; i < 3; i++) drive_cycle(0, 1, 0, 1, 0, 32'h0);
    drive_cycle(0, 1, 1, 1, 0, 32'h0);
    k = 0;
    drive_cycle(0, 1, 1, 1, 0, 32'h0);
    while (s_req !== 1'b1 && k < 10) begin drive_cycle(0, 1, 1, 1, 0, 32'h0); k++; end
    n_cmp++;
    if (s_req !== 1'b1 || s_addr !== 32'h1c00_0400) begin
      n_fail++; $display("FAIL held_next: req=%b addr=%h expected 1 1c000400", s_req, s_addr);
    end
    for (int i = 0; i < 15; i++) drive_cycle(0, 1, 1, 1, 0, 32'h0);
  endtask

  task automatic test_adef();
    drive_cycle(0, 0, 1, 1, 1, 32'h1c00_0102);
    for (int i = 0; i < 10; i++) drive_cycle(0, 0, 1, 1, 0, 32'h0);
    n_cmp++;
    if (s_vld !== 1'b1 || s_adef !== 1'b1 || s_pc !== 32'h1c00_0102 || s_instr !== 32'h0) begin
      n_fail++; $display("FAIL adef_head: valid=%b adef=%b pc=%h instr=%h expected 1 1 1c000102 0",
                         s_vld, s_adef, s_pc, s_instr);
    end
    for (int i = 0; i < 12; i++) drive_cycle(0, 1, 1, 1, 0, 32'h0);
    n_cmp++;
    if (s_vld !== 1'b0 || s_req !== 1'b0) begin
      n_fail++; $display("FAIL adef_stall: valid=%b req=%b expected 0 0", s_vld, s_req);
    end
    drive_cycle(0, 1, 1, 1, 1, 32'h1c00_0800);
    for (int i = 0; i < 12; i++) drive_cycle(0, 1, 1, 1, 0, 32'h0);
    n_cmp++;
    if (s_vld !== 1'b1) begin
      n_fail++; $display("FAIL adef_recover: valid=%b expected 1", s_vld);
    end
  endtask

  task automatic test_wrap();
    drive_cycle(0, 1, 1, 1, 1, 32'hffff_fff8);
    for (int i = 0; i < 15; i++) drive_cycle(0, 1, 1, 1, 0, 32'h0);
    n_cmp++;
    if (exp_pop_pc[31:8] !== 24'h0) begin
      n_fail++; $display("FAIL wrap: decode stream reached %h expected past 00000000", exp_pop_pc);
    end
  endtask

  task automatic test_random();
    logic [31:0] rp;
    bit rdy, aok, dok, redir;
    for (int i = 0; i < 1000; i++) begin
      rdy = ($urandom_range(0, 3) != 0);
      aok = $urandom_range(0, 1) == 1;
      dok = ($urandom_range(0, 2) != 0);
      redir = ($urandom_range(0, 63) == 0);
      rp = {16'h1c00, 14'($urandom_range(0, 16383)), 2'b00};
      if ($urandom_range(0, 7) == 0) rp[1:0] = 2'($urandom_range(1, 3));
      if (i == 500 || i == 501)
        drive_cycle(1, rdy, aok, dok, 0, 32'h0);
      else
        drive_cycle(0, rdy, aok, dok, redir, rp);
    end
  endtask

  initial begin
    bus.inst_sram_addr_ok = 1'b0;
    bus.inst_sram_data_ok = 1'b0;
    bus.inst_sram_rdata   = 32'h0;
    bus.id_ready          = 1'b0;
    bus.redirect_valid    = 1'b0;
    bus.redirect_pc       = 32'h0;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_outstanding();
    test_redirect_held();
    test_adef();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
